// File: rtl/goertzel_coeff_sequencer_pkg.sv
// Shared definitions for the Goertzel trig-coefficient sequencer:
// default widths, FSM encoding and the fix14 unity constant.
package goertzel_coeff_sequencer_pkg;

  localparam int IDX_BITS_DEF = 5;
  localparam int C_W_DEF      = 16;

  // Sequencer FSM: READY presents a valid pair, FETCH reads the table,
  // LOAD moves the read data onto the output registers.
  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // 1.0 in signed fix14.
  localparam logic [15:0] FIX14_ONE = 16'h4000;

endpackage

// File: rtl/goertzel_coeff_sequencer_table.sv
// Simple dual-port coefficient store: one write port and one registered
// read port, both on the rising edge of sys_clk. A read and a write to the
// same address in one cycle return the old contents.
module coeff_table_dp #(
  parameter int IDX_BITS = 5,
  parameter int D_W      = 32
) (
  input  logic                sys_clk,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] wr_addr_i,
  input  logic [D_W-1:0]      wr_data_i,
  input  logic                rd_en_i,
  input  logic [IDX_BITS-1:0] rd_addr_i,
  output logic [D_W-1:0]      rd_data_o
);

  logic [D_W-1:0] mem_q [2**IDX_BITS];
  logic [D_W-1:0] rd_q;

  // Table write lands at the clock edge.
  always_ff @(posedge sys_clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read, same edge as the write (read-before-write).
  always_ff @(posedge sys_clk) begin
    if (rd_en_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/goertzel_coeff_sequencer.sv
// Responder side of the Goertzel manager's coefficient handshake. Presents
// the current bin's sin/cos pair, advances one bin per accepted request,
// wraps at num_runs and reports which bin was served.
//
// Handshake: coeff_valid acts as "ready". A request_trig pulse is accepted
// only when coeff_valid=1 (FSM in READY) and num_runs!=0; the pair on
// sin_out/cos_out is the one consumed in that cycle. After an accepted
// request at edge N, coeff_valid is low until the next pair is loaded at
// edge N+2. A request while coeff_valid=0 is not accepted and sets the
// sticky req_err.
module goertzel_coeff_sequencer
  import goertzel_coeff_sequencer_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int C_W      = C_W_DEF
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  request_trig,
  input  logic [IDX_BITS-1:0]   num_runs,
  input  logic                  sweep_restart,
  input  logic                  cfg_we,
  input  logic [IDX_BITS-1:0]   cfg_addr,
  input  logic [C_W-1:0]        cfg_sin,
  input  logic [C_W-1:0]        cfg_cos,
  output logic signed [C_W-1:0] sin_out,
  output logic signed [C_W-1:0] cos_out,
  output logic                  coeff_valid,
  output logic [IDX_BITS-1:0]   served_bin,
  output logic                  sweep_done,
  output logic                  req_err,
  output state_e                dbg_state
);

  state_e                state_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [IDX_BITS-1:0]   idx_d;
  logic [IDX_BITS:0]     idx_inc;
  logic [C_W-1:0]        sin_q;
  logic [C_W-1:0]        cos_q;
  logic                  valid_q;
  logic [IDX_BITS-1:0]   served_q;
  logic                  done_q;
  logic                  err_q;
  logic [2*C_W-1:0]      rd_data;
  logic                  accept;
  logic                  last_bin;
  logic                  hit_idx;

  coeff_table_dp #(
    .IDX_BITS (IDX_BITS),
    .D_W      (2*C_W)
  ) u_table (
    .sys_clk   (sys_clk),
    .we_i      (cfg_we),
    .wr_addr_i (cfg_addr),
    .wr_data_i ({cfg_sin, cfg_cos}),
    .rd_en_i   (state_q == ST_FETCH),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  // Wrap test uses the live num_runs; an idx already past it wraps to 0.
  assign idx_inc  = {1'b0, idx_q} + (IDX_BITS+1)'(1);
  assign idx_d    = (idx_inc >= {1'b0, num_runs}) ? '0 : idx_inc[IDX_BITS-1:0];
  assign accept   = request_trig && (num_runs != '0);
  assign last_bin = (idx_q == (num_runs - IDX_BITS'(1)));
  // A config write to the bin being presented/fetched invalidates it.
  assign hit_idx  = cfg_we && (cfg_addr == idx_q);

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      idx_q    <= '0;
      sin_q    <= '0;
      cos_q    <= '0;
      valid_q  <= 1'b0;
      served_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (sweep_restart) begin
        // Restart wins over a same-cycle request, which is silently dropped.
        idx_q   <= '0;
        valid_q <= 1'b0;
        state_q <= ST_FETCH;
      end else begin
        case (state_q)
          ST_READY: begin
            if (accept) begin
              served_q <= idx_q;
              done_q   <= last_bin;
              idx_q    <= idx_d;
              valid_q  <= 1'b0;
              state_q  <= ST_FETCH;
            end else if (hit_idx) begin
              valid_q  <= 1'b0;
              state_q  <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (request_trig) err_q <= 1'b1;
            // The read this cycle returns pre-write data; read again.
            state_q <= hit_idx ? ST_FETCH : ST_LOAD;
          end
          ST_LOAD: begin
            if (request_trig) err_q <= 1'b1;
            if (hit_idx) begin
              // rd_data predates this write; never present it.
              state_q <= ST_FETCH;
            end else begin
              sin_q   <= rd_data[2*C_W-1:C_W];
              cos_q   <= rd_data[C_W-1:0];
              valid_q <= 1'b1;
              state_q <= ST_READY;
            end
          end
          default: state_q <= ST_FETCH;
        endcase
      end
    end
  end

  assign sin_out     = sin_q;
  assign cos_out     = cos_q;
  assign coeff_valid = valid_q;
  assign served_bin  = served_q;
  assign sweep_done  = done_q;
  assign req_err     = err_q;
  assign dbg_state   = state_q;

endmodule
